// File: rtl/text_cursor_writer.sv
// Converts key events into single-cycle writes of the text buffer, tracking the
// cursor, Enter/Backspace, auto-repeat, line wrap and per-line clearing.
module text_cursor_writer #(
    parameter int COLS          = 70,
    parameter int ROWS          = 30,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [7:0]  key_ascii,
    input  logic        key_pressing,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [11:0] cursor_addr,
    output logic        busy
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    localparam logic [1:0] ST_INIT_CLR = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_LINE_CLR = 2'd2;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [11:0]      CELLS      = 12'(ROWS * COLS);
    localparam logic [11:0]      LINE_LEN   = 12'(COLS);
    localparam logic [31:0]      RPT_FIRST  = 32'(REPEAT_DELAY);
    localparam logic [31:0]      RPT_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;

    function automatic logic [11:0] cellAddr(input logic [ROW_W-1:0] row,
                                             input logic [COL_W-1:0] col);
        return 12'(row) * LINE_LEN + 12'(col);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [11:0]      clrCnt_q, clrCnt_d;
    logic [ROW_W-1:0] row_q, row_d, rowNext;
    logic [COL_W-1:0] col_q, col_d;
    logic             prevKey_q;
    logic [31:0]      rptCnt_q, rptCnt_d;
    logic             pending_q, pending_d;
    logic [7:0]       pendAscii_q, pendAscii_d;
    logic             wrEn_q, wrEn_d;
    logic [11:0]      wrAddr_q, wrAddr_d;
    logic [7:0]       wrData_q, wrData_d;
    logic             keyTick, keyEvent;
    logic [7:0]       procAscii;

    // Repeat counter reloads so the next tick lands REPEAT_PERIOD cycles later.
    assign keyTick  = key_pressing && (rptCnt_q == RPT_FIRST);
    assign keyEvent = key_pressing && (!prevKey_q || keyTick);
    assign rptCnt_d = !key_pressing ? '0 : (keyTick ? RPT_RELOAD : rptCnt_q + 32'd1);

    assign cursor_addr = cellAddr(row_q, col_q);
    assign busy        = (state_q != ST_IDLE);
    assign wr_en       = wrEn_q;
    assign wr_addr     = wrAddr_q;
    assign wr_data     = wrData_q;

    always_comb begin
        state_d     = state_q;
        clrCnt_d    = clrCnt_q;
        row_d       = row_q;
        col_d       = col_q;
        pending_d   = pending_q;
        pendAscii_d = pendAscii_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        procAscii   = pending_q ? pendAscii_q : key_ascii;
        rowNext     = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

        case (state_q)
            ST_INIT_CLR: begin
                if (clrCnt_q == CELLS) begin
                    state_d  = ST_IDLE;
                    clrCnt_d = '0;
                end else begin
                    wrEn_d   = 1'b1;
                    wrAddr_d = clrCnt_q;
                    wrData_d = ASCII_SPACE;
                    clrCnt_d = clrCnt_q + 12'd1;
                end
            end
            ST_LINE_CLR: begin
                if (clrCnt_q == LINE_LEN) begin
                    state_d  = ST_IDLE;
                    clrCnt_d = '0;
                end else begin
                    wrEn_d   = 1'b1;
                    wrAddr_d = cellAddr(row_q, '0) + clrCnt_q;
                    wrData_d = ASCII_SPACE;
                    clrCnt_d = clrCnt_q + 12'd1;
                end
            end
            ST_IDLE: begin
                // A waiting event takes priority; a fresh event in that cycle is lost.
                if (pending_q || keyEvent) begin
                    pending_d = 1'b0;
                    if (procAscii >= ASCII_SPACE && procAscii <= ASCII_TILDE) begin
                        wrEn_d   = 1'b1;
                        wrAddr_d = cellAddr(row_q, col_q);
                        wrData_d = procAscii;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            row_d   = rowNext;
                            state_d = ST_LINE_CLR;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (procAscii == ASCII_CR) begin
                        col_d   = '0;
                        row_d   = rowNext;
                        state_d = ST_LINE_CLR;
                    end else if (procAscii == ASCII_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - 1'b1;
                        end else if (row_q != '0) begin
                            row_d = row_q - 1'b1;
                            col_d = LAST_COL;
                        end
                        wrEn_d   = 1'b1;
                        wrAddr_d = cellAddr(row_d, col_d);
                        wrData_d = ASCII_SPACE;
                    end
                end
            end
            default: state_d = ST_INIT_CLR;
        endcase

        if (state_q != ST_IDLE && keyEvent && !pending_q) begin
            pending_d   = 1'b1;
            pendAscii_d = key_ascii;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_INIT_CLR;
            clrCnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            prevKey_q   <= 1'b0;
            rptCnt_q    <= '0;
            pending_q   <= 1'b0;
            pendAscii_q <= '0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= ASCII_SPACE;
        end else begin
            state_q     <= state_d;
            clrCnt_q    <= clrCnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            prevKey_q   <= key_pressing;
            rptCnt_q    <= rptCnt_d;
            pending_q   <= pending_d;
            pendAscii_q <= pendAscii_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
        end
    end
endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench for text_cursor_writer: a cursor model queues every expected
// buffer write, and a negedge monitor pops and compares each write the DUT makes.
module tb_text_cursor_writer;
    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [7:0]  key_ascii = 8'h00;
    logic        key_pressing = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] cursor_addr;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] sb[$];
    logic [19:0] expWr;
    int          modelRow = 0;
    int          modelCol = 0;

    always #5 clk = ~clk;

    text_cursor_writer #(
        .COLS(COLS), .ROWS(ROWS), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk), .clrn(clrn), .key_ascii(key_ascii), .key_pressing(key_pressing),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_addr(cursor_addr), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void pushWrite(input int addr, input logic [7:0] data);
        sb.push_back({12'(addr), data});
    endfunction

    function automatic void pushLineClear(input int row);
        for (int c = 0; c < COLS; c++) pushWrite(row * COLS + c, 8'h20);
    endfunction

    function automatic void modelKey(input logic [7:0] a);
        if (a >= 8'h20 && a <= 8'h7E) begin
            pushWrite(modelRow * COLS + modelCol, a);
            if (modelCol == COLS - 1) begin
                modelCol = 0;
                modelRow = (modelRow + 1) % ROWS;
                pushLineClear(modelRow);
            end else begin
                modelCol++;
            end
        end else if (a == 8'h0D) begin
            modelCol = 0;
            modelRow = (modelRow + 1) % ROWS;
            pushLineClear(modelRow);
        end else if (a == 8'h08) begin
            if (modelCol > 0) modelCol--;
            else if (modelRow > 0) begin
                modelRow--;
                modelCol = COLS - 1;
            end
            pushWrite(modelRow * COLS + modelCol, 8'h20);
        end
    endfunction

    always @(negedge clk) begin
        if (clrn && wr_en) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_wr", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
            end else begin
                expWr = sb.pop_front();
                checkOutput("wr", 32'({wr_addr, wr_data}), 32'(expWr));
            end
        end
    end

    // Hold the key for 'hold' sampling edges; with DELAY=8/PERIOD=4 repeats fire at cycles 8,12,16...
    task automatic applyStimulus(input logic [7:0] ascii, input int hold, input logic expWen);
        int nRep;
        nRep = (hold > 8) ? (hold - 9) / 4 + 1 : 0;
        modelKey(ascii);
        for (int i = 0; i < nRep; i++) modelKey(ascii);
        @(posedge clk);
        #1;
        key_ascii    = ascii;
        key_pressing = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("latency_wen", 32'(wr_en), 32'(expWen));
        if (hold > 1) repeat (hold - 1) @(posedge clk);
        #1;
        key_pressing = 1'b0;
    endtask

    task automatic pulseKey(input logic [7:0] ascii);
        @(posedge clk);
        #1;
        key_ascii    = ascii;
        key_pressing = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        key_pressing = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic settle(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) checkOutput("settle_timeout", 32'(n), 32'(bound - 1));
        repeat (3) @(negedge clk);
    endtask

    task automatic waitInitDone(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) checkOutput("init_timeout", 32'(n), 32'(bound - 1));
        checkOutput("init_done_wen", 32'(wr_en), 32'd0);
        checkOutput("init_drain", 32'(sb.size()), 32'd0);
        checkOutput("init_cursor", 32'(cursor_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_wen", 32'(wr_en), 32'd0);
        checkOutput("rst_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_data", 32'(wr_data), 32'h20);
        checkOutput("rst_cursor", 32'(cursor_addr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);

        for (int a = 0; a < ROWS * COLS; a++) pushWrite(a, 8'h20);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        waitInitDone(2300);

        applyStimulus(8'h41, 5, 1'b1);
        settle(300);
        checkOutput("cursor_A5", 32'(cursor_addr), 32'd1);

        applyStimulus(8'h41, 20, 1'b1);
        settle(300);
        checkOutput("cursor_A20", 32'(cursor_addr), 32'd5);

        applyStimulus(8'h0D, 2, 1'b0);
        settle(300);
        checkOutput("cursor_cr1", 32'(cursor_addr), 32'd70);

        applyStimulus(8'h08, 2, 1'b1);
        settle(300);
        checkOutput("cursor_bs_up", 32'(cursor_addr), 32'd69);

        applyStimulus(8'h7A, 2, 1'b1);
        @(negedge clk);
        checkOutput("busy_wrap_clr", 32'(busy), 32'd1);
        checkOutput("cursor_wrap_clr", 32'(cursor_addr), 32'd70);
        settle(300);
        checkOutput("cursor_wrap", 32'(cursor_addr), 32'd70);

        applyStimulus(8'h08, 2, 1'b1);
        settle(300);
        checkOutput("cursor_bs_up2", 32'(cursor_addr), 32'd69);

        for (int r = 0; r < ROWS - 1; r++) begin
            applyStimulus(8'h0D, 2, 1'b0);
            settle(300);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h61 + 8'(i), 2, 1'b1);
            settle(300);
        end
        checkOutput("cursor_29_5", 32'(cursor_addr), 32'(29 * COLS + 5));

        applyStimulus(8'h0D, 2, 1'b0);
        settle(300);
        checkOutput("cursor_row_wrap", 32'(cursor_addr), 32'd0);

        applyStimulus(8'h08, 2, 1'b1);
        settle(300);
        checkOutput("cursor_bs_origin", 32'(cursor_addr), 32'd0);

        applyStimulus(8'h01, 2, 1'b0);
        settle(300);
        checkOutput("cursor_ignored", 32'(cursor_addr), 32'd0);

        applyStimulus(8'h0D, 2, 1'b0);
        checkOutput("busy_pend", 32'(busy), 32'd1);
        pulseKey(8'h42);
        pulseKey(8'h43);
        modelKey(8'h42);
        settle(300);
        checkOutput("cursor_pending", 32'(cursor_addr), 32'd71);

        applyStimulus(8'h0D, 2, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("busy_mid_clr", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        clrn = 1'b0;
        sb.delete();
        modelRow = 0;
        modelCol = 0;
        @(negedge clk);
        checkOutput("rst2_wen", 32'(wr_en), 32'd0);
        checkOutput("rst2_busy", 32'(busy), 32'd1);
        checkOutput("rst2_cursor", 32'(cursor_addr), 32'd0);
        for (int a = 0; a < ROWS * COLS; a++) pushWrite(a, 8'h20);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        waitInitDone(2300);

        applyStimulus(8'h4B, 2, 1'b1);
        settle(300);
        checkOutput("cursor_after_rst", 32'(cursor_addr), 32'd1);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
